// File: rtl/axis_insert_header_pkt_pkg.sv
// axis_hdr_pkg: shared state encoding and keep-mask helpers for the header inserter.
// Contents: state_t {IDLE, BODY, TAIL}; popcount, msb_mask(n, w), lsb_contig(keep).
// Helpers take keeps zero-extended to MAX_B lanes so any data width up to 512 bits can share them.
package axis_hdr_pkg;
  localparam int MAX_B = 64;
  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;
  function automatic int popcount(input logic [MAX_B-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_B; i++) c += int'(v[i]);
    return c;
  endfunction
  function automatic logic [MAX_B-1:0] msb_mask(input int n, input int w);
    logic [MAX_B-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_B; i++) m[i] = (i < w) && (i >= w - n);
    return m;
  endfunction
  function automatic logic lsb_contig(input logic [MAX_B-1:0] k);
    return (k & (k + 1'b1)) == '0;
  endfunction
endpackage

// File: rtl/axis_insert_header_pkt_if.sv
// axis_insert_header_pkt_if: body, header and output stream signals of the header inserter.
// Body: valid_in/ready_in/data_in/keep_in/last_in. Header: valid_insert/ready_insert/
// header_insert/keep_insert. Output: valid_out/ready_out/data_out/keep_out/last_out, err_keep.
// slave = inserter side, master = source/sink side.
interface axis_insert_header_pkt_if #(parameter int DATA_WD = 32);
  localparam int DBW = DATA_WD / 8;
  logic valid_in, ready_in, last_in;
  logic [DATA_WD-1:0] data_in;
  logic [DBW-1:0] keep_in;
  logic valid_insert, ready_insert;
  logic [DATA_WD-1:0] header_insert;
  logic [DBW-1:0] keep_insert;
  logic valid_out, ready_out, last_out, err_keep;
  logic [DATA_WD-1:0] data_out;
  logic [DBW-1:0] keep_out;
  modport slave (
    input valid_in, data_in, keep_in, last_in, valid_insert, header_insert, keep_insert, ready_out,
    output ready_in, ready_insert, valid_out, data_out, keep_out, last_out, err_keep
  );
  modport master (
    output valid_in, data_in, keep_in, last_in, valid_insert, header_insert, keep_insert, ready_out,
    input ready_in, ready_insert, valid_out, data_out, keep_out, last_out, err_keep
  );
endinterface

// File: rtl/axis_insert_header_pkt_byte_merge.sv
// axis_byte_merge: combinational byte-lane shifter joining the residual bytes with a data word.
// Ports: res (residual, valid bytes in the low h lanes), data, h (residual byte count);
// word = top lanes of {res[h bytes], data}; nres = low h bytes of data (next residual).
module axis_byte_merge #(parameter int DATA_BYTE_WD = 4) (
  input  logic [8*DATA_BYTE_WD-1:0]         res,
  input  logic [8*DATA_BYTE_WD-1:0]         data,
  input  logic [$clog2(DATA_BYTE_WD+1)-1:0] h,
  output logic [8*DATA_BYTE_WD-1:0]         word,
  output logic [8*DATA_BYTE_WD-1:0]         nres
);
  localparam int DW = 8 * DATA_BYTE_WD;
  always_comb begin
    word = DW'({res, data} >> (8 * h));
    nres = data & ~({DW{1'b1}} << (8 * h));
  end
endmodule

// File: rtl/axis_insert_header_pkt.sv
// axis_insert_header_pkt: prepends 0..DATA_BYTE_WD header bytes to each AXI-Stream packet at full rate.
// Ports: clk, rst_n (sync, active-low), bus (slave modport): body in, header in, registered output,
// sticky err_keep flagging non-contiguous keeps.
module axis_insert_header_pkt
  import axis_hdr_pkg::*;
#(parameter int DATA_WD = 32) (
  input logic clk,
  input logic rst_n,
  axis_insert_header_pkt_if.slave bus
);
  localparam int DBW = DATA_WD / 8;
  localparam int HW = $clog2(DBW + 1);
  state_t state, nxt;
  logic [DATA_WD-1:0] res, word, nres, tail_word, merge_data;
  logic [HW-1:0] h, tn;
  logic [DBW-1:0] inv_keep, tail_keep, last_keep;
  logic slot, take_in, take_hdr, take_tail, fits, bad_in, bad_hdr;
  int hk;
  assign slot = ~bus.valid_out | bus.ready_out;
  assign bus.ready_in = rst_n & (state == BODY) & slot;
  assign bus.ready_insert = rst_n & (state == IDLE);
  assign take_in = bus.valid_in & bus.ready_in;
  assign take_hdr = bus.valid_insert & bus.ready_insert;
  assign take_tail = (state == TAIL) & slot;
  // the tail beat is the residual shifted up against an all-zero word
  assign merge_data = (state == TAIL) ? '0 : bus.data_in;
  assign inv_keep = ~bus.keep_in;
  assign hk = int'(h) + popcount(MAX_B'(bus.keep_in));
  assign fits = hk <= DBW;
  assign last_keep = DBW'(msb_mask(hk, DBW));
  assign tail_keep = DBW'(msb_mask(int'(tn), DBW));
  assign bad_in = bus.last_in ? (bus.keep_in == '0 || !lsb_contig(MAX_B'(inv_keep))) : !(&bus.keep_in);
  assign bad_hdr = !lsb_contig(MAX_B'(bus.keep_insert));
  axis_byte_merge #(.DATA_BYTE_WD(DBW)) u_merge (
    .res(res), .data(merge_data), .h(h), .word(word), .nres(nres)
  );
  always_comb begin
    tail_word = '0;
    for (int i = 0; i < DBW; i++) tail_word[8*i +: 8] = word[8*i +: 8] & {8{tail_keep[i]}};
  end
  always_ff @(posedge clk) state <= rst_n ? nxt : IDLE;
  always_comb begin
    nxt = state;
    if (take_hdr) nxt = BODY;
    else if (take_in && bus.last_in) nxt = fits ? IDLE : TAIL;
    else if (take_tail) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res <= '0;
      h <= '0;
      tn <= '0;
      bus.valid_out <= 1'b0;
      bus.data_out <= '0;
      bus.keep_out <= '0;
      bus.last_out <= 1'b0;
      bus.err_keep <= 1'b0;
    end else begin
      if (take_hdr) begin
        res <= bus.header_insert;
        h <= HW'(popcount(MAX_B'(bus.keep_insert)));
      end
      if (take_in) begin
        res <= nres;
        // overflow byte count; only meaningful on a last beat that does not fit
        tn <= HW'(hk - DBW);
        bus.data_out <= word;
        bus.keep_out <= (bus.last_in && fits) ? last_keep : '1;
        bus.last_out <= bus.last_in & fits;
        bus.valid_out <= 1'b1;
      end else if (take_tail) begin
        bus.data_out <= tail_word;
        bus.keep_out <= tail_keep;
        bus.last_out <= 1'b1;
        bus.valid_out <= 1'b1;
      end else if (bus.ready_out) begin
        bus.valid_out <= 1'b0;
      end
      bus.err_keep <= bus.err_keep | (take_hdr & bad_hdr) | (take_in & bad_in);
    end
  end
endmodule

// File: tb/tb_axis_insert_header_pkt.sv
// tb_axis_insert_header_pkt: directed checks at 32 bits plus a stalled random run at 64 bits.
module tb_axis_insert_header_pkt;
  typedef struct packed { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit stall = 1'b0;
  int checks = 0;
  int errors = 0;
  beat_t q32[$];
  beat_t q64[$];
  beat_t exp64[$];
  always #5 clk = ~clk;
  axis_insert_header_pkt_if #(.DATA_WD(32)) b32();
  axis_insert_header_pkt_if #(.DATA_WD(64)) b64();
  axis_insert_header_pkt #(.DATA_WD(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  axis_insert_header_pkt #(.DATA_WD(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && b32.valid_out && b32.ready_out) q32.push_back({64'(b32.data_out), 8'(b32.keep_out), b32.last_out});
    if (rst_n && b64.valid_out && b64.ready_out) q64.push_back({b64.data_out, b64.keep_out, b64.last_out});
  end

  initial begin
    b64.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      b64.ready_out = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  task automatic hdr32(input logic [31:0] d, input logic [3:0] k);
    int t;
    t = 0;
    b32.valid_insert = 1'b1; b32.header_insert = d; b32.keep_insert = k;
    @(negedge clk);
    while (!b32.ready_insert && t < 200) begin t++; @(negedge clk); end
    if (t == 200) chk("hdr32_timeout", 80'(b32.ready_insert), 80'(1));
    @(posedge clk); #1;
    b32.valid_insert = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    t = 0;
    b32.valid_in = 1'b1; b32.data_in = d; b32.keep_in = k; b32.last_in = l;
    @(negedge clk);
    while (!b32.ready_in && t < 200) begin t++; @(negedge clk); end
    if (t == 200) chk("beat32_timeout", 80'(b32.ready_in), 80'(1));
    @(posedge clk); #1;
    b32.valid_in = 1'b0;
  endtask

  task automatic hdr64(input logic [63:0] d, input logic [7:0] k);
    int t;
    t = 0;
    b64.valid_insert = 1'b1; b64.header_insert = d; b64.keep_insert = k;
    @(negedge clk);
    while (!b64.ready_insert && t < 200) begin t++; @(negedge clk); end
    if (t == 200) chk("hdr64_timeout", 80'(b64.ready_insert), 80'(1));
    @(posedge clk); #1;
    b64.valid_insert = 1'b0;
  endtask

  task automatic beat64(input logic [63:0] d, input logic [7:0] k, input logic l);
    int t;
    t = 0;
    b64.valid_in = 1'b1; b64.data_in = d; b64.keep_in = k; b64.last_in = l;
    @(negedge clk);
    while (!b64.ready_in && t < 200) begin t++; @(negedge clk); end
    if (t == 200) chk("beat64_timeout", 80'(b64.ready_in), 80'(1));
    @(posedge clk); #1;
    b64.valid_in = 1'b0;
  endtask

  task automatic drain32();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic expect32(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    if (q32.size() == 0) chk({tag, "_missing"}, 80'(q32.size()), 80'(1));
    else begin
      b = q32.pop_front();
      chk(tag, 80'(b), 80'({64'(d), 8'(k), l}));
    end
  endtask

  initial begin
    int hn, n, kk;
    logic [63:0] hdr, d;
    logic [7:0] bq[$];
    beat_t e, g;
    b32.valid_in = 0; b32.data_in = 0; b32.keep_in = 0; b32.last_in = 0;
    b32.valid_insert = 0; b32.header_insert = 0; b32.keep_insert = 0; b32.ready_out = 1;
    b64.valid_in = 0; b64.data_in = 0; b64.keep_in = 0; b64.last_in = 0;
    b64.valid_insert = 0; b64.header_insert = 0; b64.keep_insert = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 80'(b32.valid_out), 80'(0));
    chk("rst_data", 80'(b32.data_out), 80'(0));
    chk("rst_keep", 80'(b32.keep_out), 80'(0));
    chk("rst_last", 80'(b32.last_out), 80'(0));
    chk("rst_err", 80'(b32.err_keep), 80'(0));
    chk("rst_rdy_ins", 80'(b32.ready_insert), 80'(0));
    chk("rst_rdy_in", 80'(b32.ready_in), 80'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy_ins", 80'(b32.ready_insert), 80'(1));
    chk("idle_rdy_in", 80'(b32.ready_in), 80'(0));
    @(posedge clk); #1;
    hdr32(32'hAABBCCDD, 4'b0011);
    chk("body_rdy_ins", 80'(b32.ready_insert), 80'(0));
    beat32(32'h11223344, 4'b1111, 1'b0);
    beat32(32'h55667788, 4'b1100, 1'b1);
    drain32();
    expect32("t1_b0", 32'hCCDD1122, 4'b1111, 1'b0);
    expect32("t1_b1", 32'h33445566, 4'b1111, 1'b1);
    chk("t1_extra", 80'(q32.size()), 80'(0));
    hdr32(32'hAABBCCDD, 4'b0011);
    beat32(32'h11223344, 4'b1111, 1'b0);
    beat32(32'h55667788, 4'b1110, 1'b1);
    drain32();
    expect32("t2_b0", 32'hCCDD1122, 4'b1111, 1'b0);
    expect32("t2_b1", 32'h33445566, 4'b1111, 1'b0);
    expect32("t2_tail", 32'h77000000, 4'b1000, 1'b1);
    chk("t2_extra", 80'(q32.size()), 80'(0));
    hdr32(32'hFFFFFFFF, 4'b0000);
    beat32(32'hDEADBEEF, 4'b1111, 1'b0);
    beat32(32'h01234567, 4'b1111, 1'b0);
    beat32(32'h89ABCDEF, 4'b1100, 1'b1);
    drain32();
    expect32("t3_b0", 32'hDEADBEEF, 4'b1111, 1'b0);
    expect32("t3_b1", 32'h01234567, 4'b1111, 1'b0);
    expect32("t3_b2", 32'h89ABCDEF, 4'b1100, 1'b1);
    chk("t3_extra", 80'(q32.size()), 80'(0));
    hdr32(32'hAABBCCDD, 4'b1111);
    beat32(32'h01020304, 4'b1000, 1'b1);
    drain32();
    expect32("t4_b0", 32'hAABBCCDD, 4'b1111, 1'b0);
    expect32("t4_tail", 32'h01000000, 4'b1000, 1'b1);
    chk("t4_extra", 80'(q32.size()), 80'(0));
    chk("err_clean", 80'(b32.err_keep), 80'(0));
    hdr32(32'hAABBCCDD, 4'b0011);
    beat32(32'h11223344, 4'b1111, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy_in", 80'(b32.ready_in), 80'(0));
    chk("mid_rst_rdy_ins", 80'(b32.ready_insert), 80'(0));
    @(posedge clk); #1;
    chk("mid_rst_valid", 80'(b32.valid_out), 80'(0));
    chk("mid_rst_data", 80'(b32.data_out), 80'(0));
    chk("mid_rst_keep", 80'(b32.keep_out), 80'(0));
    chk("mid_rst_last", 80'(b32.last_out), 80'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle", 80'(b32.ready_insert), 80'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_silent", 80'(q32.size()), 80'(0));
    hdr32(32'hAABBCCDD, 4'b0011);
    beat32(32'h11223344, 4'b1111, 1'b0);
    beat32(32'h55667788, 4'b1100, 1'b1);
    drain32();
    expect32("t5_b0", 32'hCCDD1122, 4'b1111, 1'b0);
    expect32("t5_b1", 32'h33445566, 4'b1111, 1'b1);
    chk("t5_extra", 80'(q32.size()), 80'(0));
    hdr32(32'hAABBCCDD, 4'b0011);
    beat32(32'h12345678, 4'b1010, 1'b1);
    drain32();
    expect32("err_b0", 32'hCCDD1234, 4'b1111, 1'b1);
    chk("err_keep_set", 80'(b32.err_keep), 80'(1));
    stall = 1'b1;
    for (int p = 0; p < 200; p++) begin
      hn = $urandom_range(0, 8);
      hdr = {$urandom, $urandom};
      for (int i = hn - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
      hdr64(hdr, 8'((9'd1 << hn) - 9'd1));
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        d = {$urandom, $urandom};
        kk = (j == n - 1) ? $urandom_range(1, 8) : 8;
        for (int i = 7; i >= 8 - kk; i--) bq.push_back(d[8*i +: 8]);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        beat64(d, 8'(((9'd1 << kk) - 9'd1) << (8 - kk)), j == n - 1);
      end
      while (bq.size() > 0) begin
        e = '0;
        for (int i = 7; i >= 0 && bq.size() > 0; i--) begin
          e.d[8*i +: 8] = bq.pop_front();
          e.k[i] = 1'b1;
        end
        e.l = bq.size() == 0;
        exp64.push_back(e);
      end
    end
    stall = 1'b0;
    for (int t = 0; t < 500 && q64.size() < exp64.size(); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("r_count", 80'(q64.size()), 80'(exp64.size()));
    for (int i = 0; i < exp64.size() && i < q64.size(); i++) begin
      g = q64[i];
      for (int b = 0; b < 8; b++) if (!g.k[b]) g.d[8*b +: 8] = 8'h00;
      chk($sformatf("r_beat%0d", i), 80'(g), 80'(exp64[i]));
    end
    chk("r_err", 80'(b64.err_keep), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
